// File: rtl/ccip_if_pkg.sv
// Minimal stand-in for the platform CCI-P package, limited to the MMIO types this block uses.
// Field names follow the platform definitions, so the real package can replace this file.
package ccip_if_pkg;
  localparam int CCIP_MMIOADDR_WIDTH = 16;
  localparam int CCIP_CLDATA_WIDTH   = 512;
  localparam int CCIP_MMIODATA_WIDTH = 64;
  localparam int CCIP_TID_WIDTH      = 9;

  typedef logic [CCIP_MMIOADDR_WIDTH-1:0] t_ccip_mmioAddr;
  typedef logic [CCIP_TID_WIDTH-1:0]      t_ccip_tid;

  typedef struct packed {
    t_ccip_mmioAddr address;
    logic [1:0]     length;
    logic           rsvd;
    t_ccip_tid      tid;
  } t_ccip_c0_ReqMmioHdr;

  typedef struct packed {
    t_ccip_c0_ReqMmioHdr          hdr;
    logic [CCIP_CLDATA_WIDTH-1:0] data;
    logic                         rspValid;
    logic                         mmioRdValid;
    logic                         mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    t_ccip_tid tid;
  } t_ccip_c2_RspMmioHdr;

  typedef struct packed {
    t_ccip_c2_RspMmioHdr            hdr;
    logic                           mmioRdValid;
    logic [CCIP_MMIODATA_WIDTH-1:0] data;
  } t_if_ccip_c2_Tx;
endpackage

// File: rtl/vai_mmio_pkg.sv
// Shared types for the MMIO initiator: tid-table entry record and err_flags bit positions.
package vai_mmio_pkg;
  import ccip_if_pkg::*;

  localparam int ERR_UNEXP_TID = 0;
  localparam int ERR_TIMEOUT   = 1;
  localparam int TIMER_W       = 16;

  typedef struct packed {
    logic               busy;
    t_ccip_mmioAddr     addr;
    logic [TIMER_W-1:0] timer;
  } t_tid_entry;
endpackage

// File: rtl/vai_mmio_tid_table.sv
// Read tid table: busy bitmap, lowest-index allocator and per-entry timeout timers.
// Timers exist only when VAI_MMIO_TIMEOUT_EN is defined; otherwise entries wait for their answer.
module vai_mmio_tid_table
  import ccip_if_pkg::*;
  import vai_mmio_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 1024,
  localparam int IDX_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       alloc_vld,
  input  t_ccip_mmioAddr             alloc_addr,
  input  logic                       free_vld,
  input  logic [IDX_W-1:0]           free_idx,
  output logic                       any_free,
  output logic [IDX_W-1:0]           alloc_idx,
  output logic [MAX_OUTSTANDING-1:0] busy,
  output t_ccip_mmioAddr             free_addr,
  output logic                       to_vld,
  output logic [IDX_W-1:0]           to_idx
);
  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 16 ||
      (MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0) begin : g_bad_max
    $error("MAX_OUTSTANDING must be a power of two in 1..16");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (1 << TIMER_W)) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES does not fit the entry timer");
  end

`ifdef VAI_MMIO_TIMEOUT_EN
  localparam logic [TIMER_W-1:0] TIMER_SAT = TIMER_W'(TIMEOUT_CYCLES);
`endif

  t_tid_entry ent_d [MAX_OUTSTANDING];
  t_tid_entry ent_q [MAX_OUTSTANDING];

  // Downward scans leave the lowest matching index in the result.
  always_comb begin
    any_free  = 1'b0;
    alloc_idx = '0;
    to_vld    = 1'b0;
    to_idx    = '0;
    busy      = '0;
    for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
      busy[i] = ent_q[i].busy;
      if (!ent_q[i].busy) begin
        any_free  = 1'b1;
        alloc_idx = IDX_W'(i);
      end
`ifdef VAI_MMIO_TIMEOUT_EN
      if (ent_q[i].busy && ent_q[i].timer == TIMER_SAT) begin
        to_vld = 1'b1;
        to_idx = IDX_W'(i);
      end
`endif
    end
    free_addr = ent_q[free_idx].addr;
  end

  always_comb begin
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      ent_d[i] = ent_q[i];
`ifdef VAI_MMIO_TIMEOUT_EN
      if (ent_q[i].busy && ent_q[i].timer != TIMER_SAT)
        ent_d[i].timer = ent_q[i].timer + TIMER_W'(1);
`endif
      if (free_vld && free_idx == IDX_W'(i))
        ent_d[i].busy = 1'b0;
      if (alloc_vld && alloc_idx == IDX_W'(i)) begin
        ent_d[i].busy  = 1'b1;
        ent_d[i].addr  = alloc_addr;
        ent_d[i].timer = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      ent_q[i].addr <= ent_d[i].addr;
      if (reset) begin
        ent_q[i].busy  <= 1'b0;
        ent_q[i].timer <= '0;
      end else begin
        ent_q[i].busy  <= ent_d[i].busy;
        ent_q[i].timer <= ent_d[i].timer;
      end
    end
  end
endmodule

// File: rtl/vai_mmio_initiator.sv
// CCI-P MMIO initiator: issues reads/writes downstream and matches read responses by tid.
// Read timeout retirement is built only when VAI_MMIO_TIMEOUT_EN is defined.
module vai_mmio_initiator
  import ccip_if_pkg::*;
  import vai_mmio_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic                           cmd_is_write,
  input  logic [CCIP_MMIOADDR_WIDTH-1:0] cmd_addr,
  input  logic [63:0]                    cmd_data,
  output t_if_ccip_c0_Rx                 mmio_c0rx,
  input  t_if_ccip_c2_Tx                 mmio_c2tx,
  output logic                           rsp_valid,
  output logic [63:0]                    rsp_data,
  output logic [CCIP_MMIOADDR_WIDTH-1:0] rsp_addr,
  output logic                           rsp_timeout,
  output logic [4:0]                     outstanding,
  output logic [1:0]                     err_flags
);
  localparam int IDX_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic                       any_free, cmd_acc, alloc_vld;
  logic [IDX_W-1:0]           alloc_idx, rsp_idx, to_idx, free_idx;
  logic [MAX_OUTSTANDING-1:0] busy;
  logic                       rsp_hit, bad_tid, to_vld, to_fire, free_vld;
  t_ccip_mmioAddr             free_addr;

  t_if_ccip_c0_Rx c0_d, c0_q;
  logic           rsp_valid_d, rsp_valid_q, rsp_timeout_d, rsp_timeout_q;
  logic [63:0]    rsp_data_d, rsp_data_q;
  t_ccip_mmioAddr rsp_addr_d, rsp_addr_q;
  logic [4:0]     outstanding_d, outstanding_q;
  logic [1:0]     err_d, err_q;

  assign cmd_ready = ~reset & (cmd_is_write | any_free);
  assign cmd_acc   = cmd_valid & cmd_ready;
  assign alloc_vld = cmd_acc & ~cmd_is_write;
  assign rsp_idx   = mmio_c2tx.hdr.tid[IDX_W-1:0];

  always_comb begin
    rsp_hit = 1'b0;
    if (!reset && mmio_c2tx.mmioRdValid && (int'(mmio_c2tx.hdr.tid) < MAX_OUTSTANDING))
      rsp_hit = busy[rsp_idx];
  end

  // A real answer owns the single rsp port; a pending timeout simply waits a cycle.
  assign bad_tid  = ~reset & mmio_c2tx.mmioRdValid & ~rsp_hit;
  assign to_fire  = ~reset & to_vld & ~rsp_hit;
  assign free_vld = rsp_hit | to_fire;
  assign free_idx = rsp_hit ? rsp_idx : to_idx;

  vai_mmio_tid_table #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .TIMEOUT_CYCLES  (TIMEOUT_CYCLES)
  ) u_tid_table (
    .clk        (clk),
    .reset      (reset),
    .alloc_vld  (alloc_vld),
    .alloc_addr (cmd_addr),
    .free_vld   (free_vld),
    .free_idx   (free_idx),
    .any_free   (any_free),
    .alloc_idx  (alloc_idx),
    .busy       (busy),
    .free_addr  (free_addr),
    .to_vld     (to_vld),
    .to_idx     (to_idx)
  );

  always_comb begin
    c0_d                 = '0;
    c0_d.mmioWrValid     = cmd_acc & cmd_is_write;
    c0_d.mmioRdValid     = alloc_vld;
    c0_d.hdr.address     = cmd_addr;
    c0_d.hdr.length      = 2'b01;
    c0_d.hdr.tid         = cmd_is_write ? '0 : t_ccip_tid'(alloc_idx);
    c0_d.data[63:0]      = cmd_data;

    rsp_valid_d   = free_vld;
    rsp_timeout_d = to_fire;
    rsp_data_d    = rsp_hit ? mmio_c2tx.data : '1;
    rsp_addr_d    = free_addr;
    outstanding_d = outstanding_q + 5'(alloc_vld) - 5'(free_vld);

    err_d = err_q;
    if (bad_tid) err_d[ERR_UNEXP_TID] = 1'b1;
    if (to_fire) err_d[ERR_TIMEOUT]   = 1'b1;
  end

  always_ff @(posedge clk) begin
    c0_q       <= c0_d;
    rsp_data_q <= rsp_data_d;
    rsp_addr_q <= rsp_addr_d;
    if (reset) begin
      c0_q.mmioRdValid <= 1'b0;
      c0_q.mmioWrValid <= 1'b0;
      c0_q.rspValid    <= 1'b0;
      rsp_valid_q      <= 1'b0;
      rsp_timeout_q    <= 1'b0;
      outstanding_q    <= '0;
      err_q            <= '0;
    end else begin
      rsp_valid_q   <= rsp_valid_d;
      rsp_timeout_q <= rsp_timeout_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
    end
  end

  assign mmio_c0rx   = c0_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_addr    = rsp_addr_q;
  assign rsp_timeout = rsp_timeout_q;
  assign outstanding = outstanding_q;
  assign err_flags   = err_q;
endmodule

// File: doc/vai_mmio_initiator.md
VAI_MMIO_INITIATOR -- requirements
Module: vai_mmio_initiator

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 4, meaning the maximum number of reads in flight (power of two, 1..16).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the number of cycles before an unanswered read is retired.
REQ-003 SHALL have port clk, input, 1, clock.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port cmd_valid, input, 1, command request.
REQ-006 SHALL have port cmd_ready, output, 1, command accepted when high with cmd_valid.
REQ-007 SHALL have port cmd_is_write, input, 1, 1 = MMIO write, 0 = MMIO read.
REQ-008 SHALL have port cmd_addr, input, CCIP_MMIOADDR_WIDTH, DWORD MMIO address.
REQ-009 SHALL have port cmd_data, input, 64, write data.
REQ-010 SHALL have port mmio_c0rx, output, t_if_ccip_c0_Rx, MMIO request to the downstream responder.
REQ-011 SHALL have port mmio_c2tx, input, t_if_ccip_c2_Tx, MMIO read response from the downstream responder.
REQ-012 SHALL have port rsp_valid, output, 1, one-cycle read-completion strobe.
REQ-013 SHALL have port rsp_data, output, 64, read data.
REQ-014 SHALL have port rsp_addr, output, CCIP_MMIOADDR_WIDTH, address of the completed read.
REQ-015 SHALL have port rsp_timeout, output, 1, completion caused by timeout.
REQ-016 SHALL have port outstanding, output, 5, count of reads in flight.
REQ-017 SHALL have port err_flags, output, 2, sticky flags: bit0 = unexpected tid, bit1 = timeout.

Function
REQ-018 SHALL drive cmd_ready = ~reset & (cmd_is_write | any tid-table entry free).
REQ-019 SHALL issue an accepted write one cycle after acceptance as mmioWrValid=1 with hdr.address=cmd_addr, hdr.length=2'b01, hdr.tid=0 and data[63:0]=cmd_data, upper bits 0.
REQ-020 SHALL, on an accepted read, allocate the lowest-index free entry, store cmd_addr, clear its timer, and issue mmioRdValid=1 one cycle later with hdr.tid=entry index, zero-extended to 9 bits.
REQ-021 SHALL hold mmioRdValid and mmioWrValid low in every cycle without an accepted command; at most one of them is high per cycle.
REQ-022 SHALL, on mmio_c2tx.mmioRdValid whose tid < MAX_OUTSTANDING and whose entry is busy:
  - pulse rsp_valid the next cycle with rsp_data=c2 data, rsp_addr=stored address and rsp_timeout=0;
  - free the entry in the same cycle as the pulse.
REQ-023 SHALL, on a response whose tid is out of range or whose entry is free, discard the response, set err_flags[0] and produce no rsp_valid.
REQ-024 SHALL allocate from the entry bitmap as it stood at the start of the cycle, so an entry freed in cycle N is allocatable from cycle N+1 only.
REQ-025 SHALL increment each busy entry's timer every cycle, saturating at TIMEOUT_CYCLES.
REQ-026 SHALL, at timer==TIMEOUT_CYCLES (timeout feature enabled):
  - pulse rsp_valid with rsp_timeout=1 and rsp_data=64'hFFFF_FFFF_FFFF_FFFF;
  - free the entry and set err_flags[1].
REQ-027 SHALL give a real response priority over a timeout on the single rsp port.
REQ-028 SHALL defer pending timeouts to later cycles in lowest-index order, one per cycle.
REQ-029 SHALL free an entry exactly once and report it exactly once when its response and its timeout coincide; the real response wins.
REQ-030 SHALL update outstanding registered, with +1 per allocation and -1 per free, both in the same cycle allowed.
REQ-031 SHALL report outstanding equal to MAX_OUTSTANDING when the table is full, with cmd_ready=0 for reads.

Reset
REQ-032 SHALL, while reset is high, force the following to 0: cmd_ready, mmio_c0rx valids, rsp_valid, rsp_timeout, outstanding, err_flags, all entry busy bits and all timers.
REQ-033 SHALL, on reset asserted mid-operation, drop in-flight reads with no rsp_valid.
REQ-034 SHALL, after reset, treat responses for tids that were in flight before reset as unexpected (REQ-023).

Configuration
REQ-035 SHALL, with VAI_MMIO_TIMEOUT_EN defined, implement timers and timeout retirement per REQ-025 to REQ-029.
REQ-036 SHALL, without VAI_MMIO_TIMEOUT_EN, omit the timers, keep rsp_timeout and err_flags[1] tied to 0, and hold entries until answered.

Structure
REQ-037 SHALL take t_if_ccip_c0_Rx, t_if_ccip_c2_Tx and CCIP_MMIOADDR_WIDTH from the platform CCI-P package.
REQ-038 SHALL put the entry record typedef (busy, address, timer) and the err_flags bit-index constants in a shared package vai_mmio_pkg.
REQ-039 SHALL implement entry bitmap, priority allocator and timers in one sub-module vai_mmio_tid_table.

Verification
REQ-040 SHALL test a single write: write addr 0x0006 data 0x5 -> mmioWrValid one cycle later with address 0x0006, data 0x5, tid 0.
REQ-041 SHALL test reads to 0x0000, 0x0002, 0x0004, 0x0008 with no responses -> tids 0,1,2,3, outstanding=4, then cmd_ready=0 for a read and 1 for a write.
REQ-042 SHALL test out-of-order responses tid 2 then tid 0 with data 0xAA, 0xBB -> rsp_addr 0x0004 then 0x0000 with matching data; a new read gets tid 0 (lowest free).
REQ-043 SHALL test a response with tid 7 when MAX_OUTSTANDING=4 -> err_flags=2'b01, no rsp_valid.
REQ-044 SHALL test timeout with TIMEOUT_CYCLES=16 and one read left unanswered -> rsp_valid with rsp_timeout=1, data all ones, err_flags[1]=1, outstanding=0; without the macro, no completion after 10000 cycles.
REQ-045 SHALL test reset asserted with 3 reads in flight -> outstanding=0, and later responses for tids 0..2 set err_flags[0].
